// File: rtl/back_end_mc.sv
// back_end_mc: per-channel write-address sequencer for a multi-channel job.
// A job writes `size` words into each channel's local memory; every channel
// advances independently and the job completes when all channels are done.
module back_end_mc #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 10
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_W:0]       size,
  input  logic [NCH-1:0]        wr,
  input  logic                  abort,
  output logic [NCH-1:0]        wren,
  output logic [NCH*ADDR_W-1:0] addr,
  output logic [NCH-1:0]        en,
  output logic [NCH-1:0]        full,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest job a channel can hold: exactly 2^ADDR_W words.
  localparam logic [ADDR_W:0]   MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_S    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   size_r;
  logic [ADDR_W-1:0] cnt_q [NCH];
  logic [NCH-1:0]    chan_done_q;

  logic [ADDR_W:0]   size_clamped;
  logic [ADDR_W:0]   last_idx;
  logic [NCH-1:0]    is_last;
  logic [NCH-1:0]    final_wr;
  logic              in_work;
  logic              all_done;

  // Job size clamp and per-channel "current address is the final word" compare.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    size_clamped = (size > MAX_SIZE) ? MAX_SIZE : size;
    last_idx     = size_r - ONE_S;
    is_last      = '0;
    for (int i = 0; i < NCH; i++) begin
      is_last[i] = ({1'b0, cnt_q[i]} == last_idx);
    end
  end

  // Write enables are combinational from wr; an abort cycle or reset writes nothing.
  always_comb begin
    in_work  = (state_q == WORK) && !areset;
    wren     = '0;
    if (in_work && !abort) begin
      wren = wr & ~chan_done_q;
    end
    final_wr = wren & is_last;
    all_done = &(chan_done_q | final_wr);
  end

  // Next-state logic: abort beats completion; unused encodings fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (size_clamped == '0) ? DONE : WORK;
        end else begin
          state_d = IDLE;
        end
      end
      WORK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (all_done) begin
          state_d = DONE;
        end else begin
          state_d = WORK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; reset forces the idle-looking output set immediately.
  always_comb begin
    busy = !areset && ((state_q == WORK) || (state_q == DONE));
    done = !areset && (state_q == DONE);
    full = in_work ? chan_done_q : '1;
    en   = wren & ~is_last;
    addr = '0;
    for (int i = 0; i < NCH; i++) begin
      addr[i*ADDR_W +: ADDR_W] = areset ? '0 : cnt_q[i];
    end
  end

  // State, captured size, channel counters and done flags.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (areset) begin
      state_q     <= IDLE;
      size_r      <= '0;
      chan_done_q <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so resetting it is cheap and required.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        size_r      <= size_clamped;
        chan_done_q <= '0;
        for (int i = 0; i < NCH; i++) begin
          cnt_q[i] <= '0;
        end
      end else if (state_q == WORK) begin
        for (int i = 0; i < NCH; i++) begin
          if (wren[i]) begin
            // The final word marks the channel done; the counter stays on the
            // last address so a full-size job never wraps back to 0.
            if (is_last[i]) begin
              chan_done_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + ONE_A;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/back_end_mc.md
BACK_END_MC -- requirements
Module: back_end_mc

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of independent output channels (1..16).
REQ-002 The block SHALL have parameter ADDR_W, default 10, per-channel local-memory address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port aclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port areset  in  1  synchronous active-high reset.
REQ-006 Port start  in  1  job start; sampled only in IDLE.
REQ-007 Port size  in  ADDR_W+1  words per channel for the job; captured when start is accepted.
REQ-008 Port wr  in  NCH  per-channel write request from the datapath.
REQ-009 Port abort  in  1  cancels the running job.
REQ-010 Port wren  out  NCH  per-channel memory write enable.
REQ-011 Port addr  out  NCH*ADDR_W  per-channel write address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 Port en  out  NCH  per-channel "more words expected" (accepted write that is not the channel's final word).
REQ-013 Port full  out  NCH  per-channel "not accepting" flag.
REQ-014 Port busy  out  1  job in progress.
REQ-015 Port done  out  1  one-cycle job-complete pulse.

Function
REQ-016 The FSM SHALL have states IDLE, WORK, DONE; any unused encoding SHALL return to IDLE on the next cycle.
REQ-017 In IDLE, start=1 SHALL capture size into size_r, clear all channel counters and done flags, and go to WORK; if size=0, it SHALL go to DONE instead.
REQ-018 A size value above 2^ADDR_W SHALL be clamped to 2^ADDR_W on capture.
REQ-019 start and size SHALL be ignored in WORK and DONE.
REQ-020 In WORK, wren[i] SHALL be wr[i] AND NOT chan_done[i], combinationally, with zero latency.
REQ-021 addr[i] SHALL equal channel counter cnt[i]; cnt[i] SHALL increment by 1 on each cycle with wren[i]=1.
REQ-022 en[i] SHALL be wren[i] AND (cnt[i] != size_r-1).
REQ-023 chan_done[i] SHALL set on the cycle after a write with cnt[i]=size_r-1; further wr[i] SHALL be dropped (wren[i]=0) and cnt[i] SHALL hold.
REQ-024 full[i] SHALL equal chan_done[i] in WORK, and 1 in IDLE and DONE.
REQ-025 WORK SHALL go to DONE on the cycle in which every channel is either already done or performs its final write; simultaneous final writes on several channels SHALL all be accepted.
REQ-026 abort=1 in WORK SHALL force IDLE on the next cycle, with no done pulse and no wren in the abort cycle; abort SHALL take priority over completion in the same cycle.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start during DONE SHALL be ignored.
REQ-029 busy SHALL be 1 in WORK and DONE, and 0 in IDLE.
REQ-030 wren and en SHALL be 0 in IDLE and DONE.
REQ-031 Channels SHALL be fully independent; a stalled channel SHALL NOT block writes on other channels.

Reset
REQ-032 areset=1 at a rising edge SHALL force IDLE, cnt[i]=0, chan_done=0 and size_r=0, overriding all other inputs, including during WORK.
REQ-033 While in reset, the outputs SHALL be: wren=0, en=0, addr=0, full=all ones, busy=0, done=0.
REQ-034 The first cycle after reset deassertion SHALL accept start.

Verification
REQ-035 NCH=2, ADDR_W=4, start with size=3, wr=2'b11 held -> addr 0,1,2 on both channels; en=1,1,0; DONE one cycle after the third write; done=1 for exactly one cycle.
REQ-036 size=4, wr[0] held, wr[1] toggling -> channel 0 finishes after 4 cycles with full[0]=1 while channel 1 continues; done only after channel 1's 4th write.
REQ-037 start with size=0 -> WORK skipped, no wren, done pulse one cycle after start.
REQ-038 abort asserted together with the final write -> wren=0 in that cycle, IDLE next cycle, done never asserted.
REQ-039 areset pulsed mid-job at cnt=2 -> next cycle IDLE with addr=0, full=all ones; a fresh start with size=2 completes normally.
REQ-040 ADDR_W=4, size=17 -> clamped to 16; addresses 0..15 written, no wrap to 0; done after the 16th write.
